// File: rtl/wt_cache_pkg.sv
// Shared types and default geometry for the write-through L1 data cache.
// Sequencer states for the dcache flush/init controller.
package wt_cache_pkg;

    localparam int unsigned DCACHE_NUM_WORDS = 256;
    localparam int unsigned DCACHE_SET_ASSOC = 8;

    typedef enum logic [2:0] {
        FLUSH_RESET = 3'd0,
        FLUSH_DRAIN = 3'd1,
        FLUSH_INVAL = 3'd2,
        FLUSH_ACK   = 3'd3,
        FLUSH_IDLE  = 3'd4
    } flush_state_e;

endpackage

// File: rtl/wt_dcache_flush_ctrl.sv
// Dcache management sequencer: owns cache enable, drains traffic and walks every
// set with full-way invalidations on init, flush request and cache disable.
module wt_dcache_flush_ctrl
    import wt_cache_pkg::*;
#(
    parameter  int unsigned NumSets  = DCACHE_NUM_WORDS,
    parameter  int unsigned NumWays  = DCACHE_SET_ASSOC,
    localparam int unsigned IdxWidth = $clog2(NumSets)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                flush_i,
    input  logic                busy_i,
    input  logic                wbuffer_empty_i,
    input  logic                inv_gnt_i,
    output logic                stall_o,
    output logic                inv_vld_o,
    output logic [IdxWidth-1:0] inv_idx_o,
    output logic [NumWays-1:0]  inv_we_o,
    output logic                cache_en_o,
    output logic                flush_ack_o,
    output logic                busy_o
);

    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumSets - 1);

    flush_state_e        state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic                flush_pend_q, flush_pend_d;
    logic                cache_en_q, cache_en_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= FLUSH_RESET;
            idx_q        <= '0;
            flush_pend_q <= 1'b0;
            cache_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            flush_pend_q <= flush_pend_d;
            cache_en_q   <= cache_en_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        flush_pend_d = flush_pend_q;
        cache_en_d   = cache_en_q;
        case (state_q)
            // No traffic can exist straight out of reset, so init skips the drain.
            FLUSH_RESET: state_d = FLUSH_INVAL;
            FLUSH_IDLE: begin
                cache_en_d = enable_i;
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                    state_d      = FLUSH_DRAIN;
                end else if (cache_en_q && !enable_i) begin
                    state_d = FLUSH_DRAIN;
                end
            end
            FLUSH_DRAIN: begin
                cache_en_d = 1'b0;
                if (!busy_i && wbuffer_empty_i) begin
                    state_d = FLUSH_INVAL;
                end
            end
            FLUSH_INVAL: begin
                if (inv_gnt_i) begin
                    // Power-of-two set count: the increment wraps to 0 after the last set.
                    idx_d = idx_q + IdxWidth'(1);
                    if (idx_q == LastIdx) begin
                        state_d = flush_pend_q ? FLUSH_ACK : FLUSH_IDLE;
                    end
                end
            end
            FLUSH_ACK: begin
                flush_pend_d = 1'b0;
                state_d      = FLUSH_IDLE;
            end
            default: state_d = FLUSH_RESET;
        endcase
    end

    assign inv_idx_o = idx_q;

    always_comb begin
        stall_o     = 1'b1;
        inv_vld_o   = 1'b0;
        inv_we_o    = '0;
        cache_en_o  = 1'b0;
        flush_ack_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            FLUSH_INVAL: begin
                inv_vld_o = 1'b1;
                inv_we_o  = '1;
            end
            FLUSH_ACK: flush_ack_o = 1'b1;
            FLUSH_IDLE: begin
                stall_o    = 1'b0;
                cache_en_o = cache_en_q;
                busy_o     = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wt_dcache_flush_ctrl.sv
// Bench for wt_dcache_flush_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a phase-level reference model.
module tb_wt_dcache_flush_ctrl;

    localparam int NS = 256;
    localparam int NW = 8;
    localparam int M_RST = 0, M_DRN = 1, M_INV = 2, M_ACK = 3, M_IDL = 4;

    logic          clk = 1'b0;
    logic          rst, enable, flush, busy, wbe, gnt;
    logic          stall_o, inv_vld_o, cache_en_o, flush_ack_o, busy_o;
    logic [7:0]    inv_idx_o;
    logic [NW-1:0] inv_we_o;

    int checks = 0;
    int errors = 0;

    wt_dcache_flush_ctrl #(.NumSets(NS), .NumWays(NW)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
        .busy_i(busy), .wbuffer_empty_i(wbe), .inv_gnt_i(gnt),
        .stall_o(stall_o), .inv_vld_o(inv_vld_o), .inv_idx_o(inv_idx_o),
        .inv_we_o(inv_we_o), .cache_en_o(cache_en_o), .flush_ack_o(flush_ack_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: which phase of the management sequence we are in,
    // how far the set walk has got, and whether the sequence owes an ack.
    int   ph;
    int   cnt;
    logic pend, en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= M_RST; cnt <= 0; pend <= 1'b0; en <= 1'b0;
        end else begin
            case (ph)
                M_RST: ph <= M_INV;
                M_IDL: begin
                    en <= enable;
                    if (flush) begin
                        pend <= 1'b1; ph <= M_DRN;
                    end else if (en && !enable) begin
                        ph <= M_DRN;
                    end
                end
                M_DRN: begin
                    en <= 1'b0;
                    if (!busy && wbe) ph <= M_INV;
                end
                M_INV: if (gnt) begin
                    cnt <= (cnt + 1) % NS;
                    if (cnt == NS - 1) ph <= pend ? M_ACK : M_IDL;
                end
                default: begin
                    pend <= 1'b0; ph <= M_IDL;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("stall_o", stall_o, ph != M_IDL);
        check("busy_o", busy_o, ph != M_IDL);
        check("inv_vld_o", inv_vld_o, ph == M_INV);
        check("inv_we_o", inv_we_o, (ph == M_INV) ? {NW{1'b1}} : '0);
        check("cache_en_o", cache_en_o, (ph == M_IDL) && en);
        check("flush_ack_o", flush_ack_o, ph == M_ACK);
        if (ph == M_INV) check("inv_idx_o", inv_idx_o, cnt);
    end

    // Event counters and walk-order tracker sampled on the active edge.
    int vld_cnt = 0, ack_cnt = 0, seq_err = 0, exp_next = 0;
    always @(posedge clk) begin
        if (rst) begin
            exp_next <= 0;
        end else begin
            if (inv_vld_o) vld_cnt <= vld_cnt + 1;
            if (flush_ack_o) ack_cnt <= ack_cnt + 1;
            if (inv_vld_o && gnt) begin
                if (int'(inv_idx_o) != exp_next) seq_err <= seq_err + 1;
                exp_next <= (int'(inv_idx_o) + 1) % NS;
            end
        end
    end

    initial begin
        int n, k, v0, a0;
        logic t;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; busy = 1'b0; wbe = 1'b1; gnt = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stall", stall_o, 1);
        check("rst_busy", busy_o, 1);
        check("rst_cache_en", cache_en_o, 0);
        check("rst_idx", inv_idx_o, 0);

        // Init walk after reset release
        v0 = vld_cnt; a0 = ack_cnt;
        rst = 1'b0;
        n = 1;
        while (n < 1000) begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
        end
        check("init_stall_cycles", n, 257);
        check("init_inval_count", vld_cnt - v0, 256);
        check("init_no_ack", ack_cnt - a0, 0);

        enable = 1'b1;
        @(negedge clk);
        check("enable_rise", cache_en_o, 1);

        // Flush with 5 busy drain cycles
        flush = 1'b1; busy = 1'b1; v0 = vld_cnt; a0 = ack_cnt;
        k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (k == 1) flush = 1'b0;
            if (k == 6) busy = 1'b0;
            if (flush_ack_o) break;
        end
        check("flush_latency", k, 263);
        repeat (2) @(negedge clk);
        check("flush_en_restore", cache_en_o, 1);
        check("flush_inval_count", vld_cnt - v0, 256);
        check("flush_ack_count", ack_cnt - a0, 1);

        // Alternating grant: each index held two cycles
        flush = 1'b1; v0 = vld_cnt; t = 1'b0; k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (inv_vld_o) begin
                gnt = t; t = ~t;
            end else begin
                gnt = 1'b1;
            end
            if (flush_ack_o) begin
                flush = 1'b0;
                break;
            end
        end
        gnt = 1'b1;
        check("toggle_inval_cycles", vld_cnt - v0, 512);
        check("toggle_walk_order", seq_err, 0);

        // Disable edge without flush
        repeat (2) @(negedge clk);
        enable = 1'b0; v0 = vld_cnt; a0 = ack_cnt;
        repeat (300) @(negedge clk);
        check("disable_inval_count", vld_cnt - v0, 256);
        check("disable_no_ack", ack_cnt - a0, 0);
        check("disable_en_off", cache_en_o, 0);

        // Flush and disable together, flush held into the cycle after ack
        enable = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b1; enable = 1'b0; v0 = vld_cnt; a0 = ack_cnt; k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (flush_ack_o) break;
        end
        @(negedge clk);
        flush = 1'b0;
        repeat (300) @(negedge clk);
        check("combo_latency", k, 258);
        check("combo_ack_count", ack_cnt - a0, 1);
        check("combo_inval_count", vld_cnt - v0, 256);

        // Reset in the middle of a flush walk
        enable = 1'b1;
        repeat (2) @(negedge clk);
        flush = 1'b1; k = 0;
        while (k < 2000) begin
            @(negedge clk);
            k++;
            if (inv_vld_o && inv_idx_o == 8'd100) break;
        end
        check("midrst_reached_100", inv_idx_o, 100);
        #2 rst = 1'b1;
        #1;
        check("midrst_stall", stall_o, 1);
        check("midrst_vld", inv_vld_o, 0);
        check("midrst_idx", inv_idx_o, 0);
        check("midrst_we", inv_we_o, 0);
        check("midrst_ack", flush_ack_o, 0);
        check("midrst_busy", busy_o, 1);
        flush = 1'b0; a0 = ack_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (k < 50) begin
            @(negedge clk);
            k++;
            if (inv_vld_o) break;
        end
        check("midrst_restart_idx", inv_idx_o, 0);
        repeat (300) @(negedge clk);
        check("midrst_no_ack", ack_cnt - a0, 0);
        check("midrst_walk_order", seq_err, 0);

        // Randomized traffic, including resets with flush held high
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 15) == 0) enable = ~enable;
            flush = ($urandom_range(0, 199) == 0);
            busy  = ($urandom_range(0, 2) == 0);
            wbe   = ($urandom_range(0, 3) != 0);
            gnt   = ($urandom_range(0, 3) != 0);
            rst   = (i >= 1500 && i < 1502) || (i >= 2500 && i < 2502);
            if (i >= 2500 && i < 2505) flush = 1'b1;
        end
        rst = 1'b0; flush = 1'b0; busy = 1'b0; wbe = 1'b1; gnt = 1'b1;
        repeat (600) @(negedge clk);
        check("random_walk_order", seq_err, 0);
        check("random_settled_idle", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
